// File: rtl/pslip_sched_pkg.sv
// Shared types and width helpers for the priority-aware iSLIP scheduler.
package pslip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned P_DEF = 4;

  // Widths never collapse to zero so degenerate configs still elaborate.
  function automatic int unsigned pri_w(input int unsigned p);
    return (p > 2) ? $clog2(p) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned C_DEF  = pri_w(P_DEF);
  localparam int unsigned IW_DEF = idx_w(N_DEF);

endpackage

// File: rtl/pslip_sched_arb.sv
// N-way max-priority arbiter with round-robin tiebreak starting at ptr.
// PSLIP_SCHED_PRIO_EN: when undefined every nonzero priority counts as equal.
module pri_rr_arb
  import pslip_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  parameter  int unsigned C  = C_DEF,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [C-1:0]  pri [0:N-1],
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [C-1:0]  w_eff [0:N-1];
  logic [C-1:0]  w_max;
  logic [IW-1:0] w_idx;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
`ifdef PSLIP_SCHED_PRIO_EN
      w_eff[k] = pri[k];
`else
      w_eff[k] = C'(pri[k] != '0);
`endif
    end
  end

  always_comb begin
    w_max = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_eff[k] > w_max) w_max = w_eff[k];
    end
  end

  // First requester at the maximum level, scanning ptr, ptr+1, ... mod N.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IW'((32'(ptr) + k) % N);
      if (!valid && (w_eff[w_idx] != '0) && (w_eff[w_idx] == w_max)) begin
        gnt[w_idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pslip_sched.sv
// Iterative priority-aware iSLIP scheduler producing one conflict-free matching per round.
// PSLIP_SCHED_PRIO_EN selects priority-first arbitration; undefined gives pure round-robin iSLIP.
module pslip_sched
  import pslip_pkg::*;
#(
  parameter  int unsigned N    = N_DEF,
  parameter  int unsigned P    = P_DEF,
  parameter  int unsigned ITER = 2,
  localparam int unsigned C    = pri_w(P),
  localparam int unsigned IW   = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [C-1:0]  req_pri [0:N-1][0:N-1],
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  match_valid,
  output logic [IW-1:0] match_out [0:N-1]
);

  localparam int unsigned TW = idx_w(ITER);

  sched_state_t  r_state, w_next;

  logic [C-1:0]  r_req       [0:N-1][0:N-1];
  logic [N-1:0]  r_grant     [0:N-1];
  logic [IW-1:0] r_gptr      [0:N-1];
  logic [IW-1:0] r_aptr      [0:N-1];
  logic [TW-1:0] r_iter;
  logic [N-1:0]  r_out_used;
  logic [N-1:0]  r_match_valid;
  logic [IW-1:0] r_match_out [0:N-1];

  logic [C-1:0]  w_gpri [0:N-1][0:N-1];
  logic [C-1:0]  w_apri [0:N-1][0:N-1];
  logic [N-1:0]  w_gnt  [0:N-1];
  logic [N-1:0]  w_gnt_v;
  logic [N-1:0]  w_acc  [0:N-1];
  logic [N-1:0]  w_acc_v;
  logic          w_last_iter;

  assign match_valid = r_match_valid;
  assign match_out   = r_match_out;
  assign w_last_iter = !(32'(r_iter) < ITER - 1);

  // Grant vectors are indexed by output (over inputs); accept vectors by input (over outputs).
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < N; i++) begin
        w_gpri[j][i] = (r_match_valid[i] || r_out_used[j]) ? '0 : r_req[i][j];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        w_apri[i][j] = (r_grant[j][i] && !r_match_valid[i]) ? r_req[i][j] : '0;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_arb
    pri_rr_arb #(.N(N), .C(C)) u_garb (
      .pri   (w_gpri[g]),
      .ptr   (r_gptr[g]),
      .gnt   (w_gnt[g]),
      .valid (w_gnt_v[g])
    );
    pri_rr_arb #(.N(N), .C(C)) u_aarb (
      .pri   (w_apri[g]),
      .ptr   (r_aptr[g]),
      .gnt   (w_acc[g]),
      .valid (w_acc_v[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = GRANT;
      GRANT:   w_next = ACCEPT;
      ACCEPT:  w_next = w_last_iter ? DONE : GRANT;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_iter        <= '0;
      r_out_used    <= '0;
      r_match_valid <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        r_match_out[k] <= '0;
        r_gptr[k]      <= '0;
        r_aptr[k]      <= '0;
        r_grant[k]     <= '0;
        for (int unsigned m = 0; m < N; m++) r_req[k][m] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_req         <= req_pri;
            r_iter        <= '0;
            r_out_used    <= '0;
            r_match_valid <= '0;
            for (int unsigned k = 0; k < N; k++) r_match_out[k] <= '0;
          end
        end
        GRANT: begin
          for (int unsigned j = 0; j < N; j++) r_grant[j] <= w_gnt_v[j] ? w_gnt[j] : '0;
        end
        ACCEPT: begin
          // Each output grants at most one input, so at most one input accepts any given j.
          for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
              if (w_acc_v[i] && w_acc[i][j]) begin
                r_match_valid[i] <= 1'b1;
                r_match_out[i]   <= IW'(j);
                r_out_used[j]    <= 1'b1;
                if (r_iter == '0) begin
                  r_aptr[i] <= IW'((j + 1) % N);
                  r_gptr[j] <= IW'((i + 1) % N);
                end
              end
            end
          end
          if (!w_last_iter) r_iter <= r_iter + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pslip_sched.sv
// Directed self-checking bench for pslip_sched (ITER=2 main instance, ITER=1 companion).
module tb_pslip_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] req [0:3][0:3];
  logic       busy, done, busy1, done1;
  logic [3:0] mv, mv1;
  logic [1:0] mo  [0:3];
  logic [1:0] mo1 [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pslip_sched #(.N(4), .P(4), .ITER(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .req_pri(req),
    .busy(busy), .done(done), .match_valid(mv), .match_out(mo)
  );

  pslip_sched #(.N(4), .P(4), .ITER(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .req_pri(req),
    .busy(busy1), .done(done1), .match_valid(mv1), .match_out(mo1)
  );

  task automatic clear_req();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) req[i][j] = 2'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mv !== 4'b0000) begin errors++; $display("FAIL reset_mv: got %b expected 0000", mv); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (mo[k] !== 2'd0) begin errors++; $display("FAIL reset_mo%0d: got %0d expected 0", k, mo[k]); end
    end
  endtask

  task automatic test_single();
    int lat;
    clear_req();
    req[2][1] = 2'd3;
    launch();
    wait_done(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d expected 5", lat); end
    checks++; if (mv !== 4'b0100) begin errors++; $display("FAIL single_mv: got %b expected 0100", mv); end
    checks++; if (mo[2] !== 2'd1) begin errors++; $display("FAIL single_mo2: got %0d expected 1", mo[2]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    checks++; if (mv !== 4'b0100) begin errors++; $display("FAIL single_hold_mv: got %b expected 0100", mv); end
  endtask

  task automatic test_priority();
    int lat;
    logic [3:0] exp_mv;
    int exp_in;
    apply_reset();
    clear_req();
    req[0][0] = 2'd1;
    req[3][0] = 2'd3;
`ifdef PSLIP_SCHED_PRIO_EN
    exp_mv = 4'b1000; exp_in = 3;
`else
    exp_mv = 4'b0001; exp_in = 0;
`endif
    launch();
    wait_done(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL prio_latency: got %0d expected 5", lat); end
    checks++; if (mv !== exp_mv) begin errors++; $display("FAIL prio_mv: got %b expected %b", mv, exp_mv); end
    checks++; if (mo[exp_in] !== 2'd0) begin errors++; $display("FAIL prio_mo: got %0d expected 0", mo[exp_in]); end
  endtask

  task automatic test_fairness();
    int lat;
    logic [3:0] exp_mv [0:2];
    exp_mv[0] = 4'b0001; exp_mv[1] = 4'b0010; exp_mv[2] = 4'b0001;
    apply_reset();
    clear_req();
    req[0][0] = 2'd2;
    req[1][0] = 2'd2;
    for (int r = 0; r < 3; r++) begin
      launch();
      wait_done(lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL fair_latency_r%0d: got %0d expected 5", r, lat); end
      checks++; if (mv !== exp_mv[r]) begin errors++; $display("FAIL fair_mv_r%0d: got %b expected %b", r, mv, exp_mv[r]); end
    end
  endtask

  task automatic test_second_iter();
    int lat;
    apply_reset();
    clear_req();
    req[0][0] = 2'd2; req[0][1] = 2'd2;
    req[1][0] = 2'd2; req[1][1] = 2'd2;
    launch();
    wait_done(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL iter_latency: got %0d expected 5", lat); end
    checks++; if (mv !== 4'b0011) begin errors++; $display("FAIL iter2_mv: got %b expected 0011", mv); end
    checks++; if (mo[0] !== 2'd0) begin errors++; $display("FAIL iter2_mo0: got %0d expected 0", mo[0]); end
    checks++; if (mo[1] !== 2'd1) begin errors++; $display("FAIL iter2_mo1: got %0d expected 1", mo[1]); end
    checks++; if (mv1 !== 4'b0001) begin errors++; $display("FAIL iter1_mv: got %b expected 0001", mv1); end
    checks++; if (mo1[0] !== 2'd0) begin errors++; $display("FAIL iter1_mo0: got %0d expected 0", mo1[0]); end
    launch();
    wait_done(lat);
    checks++; if (mv !== 4'b0011) begin errors++; $display("FAIL iter2_r2_mv: got %b expected 0011", mv); end
    checks++; if (mo[0] !== 2'd1) begin errors++; $display("FAIL iter2_r2_mo0: got %0d expected 1", mo[0]); end
    checks++; if (mo[1] !== 2'd0) begin errors++; $display("FAIL iter2_r2_mo1: got %0d expected 0", mo[1]); end
    checks++; if (mo1[1] !== 2'd0) begin errors++; $display("FAIL iter1_r2_mo1: got %0d expected 0", mo1[1]); end
  endtask

  task automatic test_start_busy();
    int n_done;
    int first;
    apply_reset();
    clear_req();
    req[2][1] = 2'd3;
    launch();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    first  = 0;
    for (int k = 3; k < 18; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first == 0) first = k;
      end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_start_dones: got %0d expected 1", n_done); end
    checks++; if (first !== 5) begin errors++; $display("FAIL busy_start_latency: got %0d expected 5", first); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
    checks++; if (mv !== 4'b0100) begin errors++; $display("FAIL busy_start_mv: got %b expected 0100", mv); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    int lat;
    apply_reset();
    clear_req();
    req[0][0] = 2'd2;
    req[1][0] = 2'd2;
    launch();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (mv !== 4'b0000) begin errors++; $display("FAIL midrst_mv: got %b expected 0000", mv); end
    reset  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", n_done); end
    launch();
    wait_done(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_latency: got %0d expected 5", lat); end
    checks++; if (mv !== 4'b0001) begin errors++; $display("FAIL midrst_ptr_mv: got %b expected 0001", mv); end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_req();
    test_reset();
    test_single();
    test_priority();
    test_fairness();
    test_second_iter();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
